ram_2p_port_ctrl: RTL
=====================

Name: ram_2p_port_ctrl

Overview:
Single-port request front-end that drives one port (A or B) of the synchronous dual-port RAM model.
- Accepts valid/ready requests and range-checks the address.
- Expands byte enables to the RAM's full bit write mask.
- Captures the RAM's 1-cycle registered read data into a small response FIFO, so a stalled consumer never loses data.
- One instance per RAM port. Both instances share the RAM but each runs on its own clock domain.

Parameters:
- Width, 32, data width in bits; must be a multiple of 8.
- Depth, 128, number of RAM words; need not be a power of two.
- RspDepth, 3, response FIFO entries; minimum 3 for full throughput.
- Aw, $clog2(Depth), derived address width (localparam).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_write_i  in  1  1=write, 0=read
- req_addr_i  in  Aw  word address
- req_wdata_i  in  Width  write data
- req_be_i  in  Width/8  byte enables for writes
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  Width  read data; 0 for writes and errors
- rsp_err_o  out  1  address out of range
- ram_req_o  out  1  to RAM x_req_i
- ram_write_o  out  1  to RAM x_write_i
- ram_addr_o  out  Aw  to RAM x_addr_i
- ram_wdata_o  out  Width  to RAM x_wdata_i
- ram_wmask_o  out  Width  to RAM x_wmask_i, full bit mask
- ram_rdata_i  in  Width  from RAM x_rdata_o

Behaviour:
- Clock and reset: one clock (clk_i). Reset is asynchronous and active-low (rst_ni).
- Reset state:
  - FIFO empty, pending flag clear.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - req_ready_o=1 once rst_ni is high.
- Accept: acc = req_valid_i & req_ready_o. Requests may arrive back-to-back, one per cycle.
- Range check: err = (req_addr_i >= Depth).
- RAM drive (combinational, same cycle as accept):
  - ram_req_o = acc & ~err.
  - ram_write_o, ram_addr_o and ram_wdata_o pass through from the request.
  - ram_wmask_o[j] = req_be_i[j/8] on writes, all-zero on reads.
  - A write with be=0 still issues ram_req_o and writes nothing.
- Pending stage: on acc, register {pend=1, is_rd=~req_write_i, err}; otherwise pend=0.
- Capture: in the cycle pend=1, push one FIFO entry at the next edge:
  - rdata = (is_rd & ~err) ? ram_rdata_i : 0.
  - err = the registered err.
- Ordering: every accepted request, read, write or error, produces exactly one response, in order.
- Latency: a request accepted on edge N has rsp_valid_o=1 from cycle N+2. No bypass.
- FIFO head: rsp_valid_o = (count != 0). rsp_rdata_o and rsp_err_o show the head entry and are held stable while valid & ~ready. Pop on rsp_valid_o & rsp_ready_i.
- Flow control:
  - req_ready_o = (count + pend) < RspDepth, using registered count only.
  - No combinational path from rsp_ready_i or req_valid_i to req_ready_o.
  - With RspDepth=3 and rsp_ready_i held 1, sustained throughput is 1 request/cycle.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Full FIFO: cannot overflow, because credit covers the in-flight pending entry.
- Pointer wrap: pointers wrap modulo RspDepth; RspDepth need not be a power of two.
- Reset mid-operation: pending and FIFO contents are discarded and no stale response appears afterwards. RAM contents are untouched.
- Elaboration assertions:
  - Width%8==0.
  - RspDepth>=2.
- Runtime assertions:
  - No push while full.
  - rsp_* stable while valid & ~ready.
  - Address known (not X) when req_valid_i.

Test Plan:
- Write addr 5 data 0xDEADBEEF be=4'hF, then read addr 5 -> two responses: first rdata 0 err 0; second rdata 0xDEADBEEF err 0, valid 2 cycles after accept.
- Write 0x11223344 to addr 7, then write 0xAABBCCDD be=4'b0101, read addr 7 -> rdata 0x11BB33DD; ram_wmask_o on the second write = 0x00FF00FF.
- rsp_ready_i=1, 8 back-to-back reads of addrs 0..7 -> req_ready_o never drops, responses in address order on 8 consecutive cycles.
- rsp_ready_i=0, issue reads continuously -> exactly 3 accepted, then req_ready_o=0. Raise rsp_ready_i -> 3 responses drain in order, req_ready_o returns, no loss or duplication.
- Depth=100, read addr 100 and write addr 127 -> ram_req_o stays 0; both responses err=1, rdata 0. Next read of addr 99 -> err=0.
- Assert rst_ni low with 2 entries queued and 1 pending -> rsp_valid_o=0 immediately (asynchronous). After release no responses appear and req_ready_o=1.

Source files
------------

// File: rtl/ram_2p_port_ctrl.sv
// Valid/ready request front-end for one port of the synchronous dual-port RAM.
// Range-checks addresses, expands byte enables and queues ordered responses.
module ram_2p_port_ctrl #(
  parameter int Width    = 32,
  parameter int Depth    = 128,
  parameter int RspDepth = 3,
  localparam int Aw      = $clog2(Depth)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_write_i,
  input  logic [Aw-1:0]      req_addr_i,
  input  logic [Width-1:0]   req_wdata_i,
  input  logic [Width/8-1:0] req_be_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [Width-1:0]   rsp_rdata_o,
  output logic               rsp_err_o,
  output logic               ram_req_o,
  output logic               ram_write_o,
  output logic [Aw-1:0]      ram_addr_o,
  output logic [Width-1:0]   ram_wdata_o,
  output logic [Width-1:0]   ram_wmask_o,
  input  logic [Width-1:0]   ram_rdata_i
);

  localparam int CntW = $clog2(RspDepth + 1);
  localparam int PtrW = $clog2(RspDepth);
  localparam logic [Aw:0]       DepthLim  = (Aw + 1)'(Depth);
  localparam logic [CntW:0]     CreditLim = (CntW + 1)'(RspDepth);
  localparam logic [PtrW-1:0]   PtrLast   = PtrW'(RspDepth - 1);

  if (Width % 8 != 0) begin : gen_bad_width
    $error("ram_2p_port_ctrl: Width must be a multiple of 8");
  end
  if (RspDepth < 2) begin : gen_bad_rsp_depth
    $error("ram_2p_port_ctrl: RspDepth must be at least 2");
  end

  logic             acc;
  logic             addr_err;
  logic             pend_q;
  logic             pend_rd_q;
  logic             pend_err_q;
  logic [CntW-1:0]  count_q;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic             push;
  logic             pop;
  logic [Width-1:0] push_rdata;
  logic [Width-1:0] fifo_rdata_q [RspDepth];
  logic             fifo_err_q   [RspDepth];

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrLast) ? '0 : ptr + PtrW'(1);
  endfunction

  // Credit counts the in-flight pending entry, so the FIFO can never overflow.
  assign req_ready_o = ({1'b0, count_q} + {{CntW{1'b0}}, pend_q}) < CreditLim;
  assign acc         = req_valid_i & req_ready_o;
  assign addr_err    = {1'b0, req_addr_i} >= DepthLim;

  assign ram_req_o   = acc & ~addr_err;
  assign ram_write_o = req_write_i;
  assign ram_addr_o  = req_addr_i;
  assign ram_wdata_o = req_wdata_i;

  always_comb begin
    for (int j = 0; j < Width; j++) begin
      ram_wmask_o[j] = req_write_i & req_be_i[j/8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q     <= 1'b0;
      pend_rd_q  <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      pend_q     <= acc;
      pend_rd_q  <= acc & ~req_write_i;
      pend_err_q <= acc & addr_err;
    end
  end

  assign push       = pend_q;
  assign pop        = rsp_valid_o & rsp_ready_i;
  assign push_rdata = (pend_rd_q & ~pend_err_q) ? ram_rdata_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; outputs are gated by rsp_valid_o so stale entries never leak.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rdata_q[wr_ptr_q] <= push_rdata;
      fifo_err_q[wr_ptr_q]   <= pend_err_q;
    end
  end

  assign rsp_valid_o = (count_q != '0);
  assign rsp_rdata_o = rsp_valid_o ? fifo_rdata_q[rd_ptr_q] : '0;
  assign rsp_err_o   = rsp_valid_o & fifo_err_q[rd_ptr_q];

`ifndef SYNTHESIS
  a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> ({1'b0, count_q} < CreditLim));
  a_rsp_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid_o && !rsp_ready_i) |=>
      (rsp_valid_o && $stable(rsp_rdata_o) && $stable(rsp_err_o)));
  a_addr_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_valid_i |-> !$isunknown(req_addr_i));
`endif

endmodule
